control_unit: RTL and testbench

Single-cycle ARM control unit: decodes `Instr` and the registered NZCV condition flags, then drives every control input of `DATAPATH`. These are `RegSrc`, `RegWrite`, `ImmSrc`, `ALUSrc`, `ALUControl`, `MemtoReg`, `PCSrc`, plus `MemWrite` to data memory. It holds the architectural flag register, updated from `ALUFlags` under conditional execution.

---
 rtl/control_unit.sv | 201 ++++++++++++++++++++
 tb/tb_control_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Single-cycle ARM control unit: instruction decode, condition check and NZCV flag register.
// Optional CMP/TST support is enabled by defining CONTROL_CMP_EN.
module control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic [1:0]  RegSrc,
    output logic        RegWrite,
    output logic [1:0]  ImmSrc,
    output logic        ALUSrc,
    output logic [1:0]  ALUControl,
    output logic        MemtoReg,
    output logic        MemWrite,
    output logic        PCSrc,
    output logic [3:0]  Flags
);

    logic [3:0] cond_s;
    logic [1:0] op_s;
    logic [5:0] funct_s;
    logic [3:0] rd_s;
    logic [3:0] cmd_s;

    logic       branch_s;
    logic       mem_to_reg_s;
    logic       mem_w_s;
    logic       alu_src_s;
    logic [1:0] imm_src_s;
    logic       reg_w_s;
    logic [1:0] reg_src_s;
    logic       alu_op_s;

    logic [1:0] alu_control_s;
    logic [1:0] flag_w_s;
    logic       cmd_ok_s;
    logic       no_write_s;

    logic       reg_w_eff_s;
    logic       mem_w_eff_s;
    logic       pcs_s;
    logic       cond_ex_s;

    logic [3:0] flags_d;
    logic [3:0] flags_q;

    logic       unused_s;

    assign cond_s   = Instr[31:28];
    assign op_s     = Instr[27:26];
    assign funct_s  = Instr[25:20];
    assign rd_s     = Instr[15:12];
    assign cmd_s    = funct_s[4:1];
    assign unused_s = ^{Instr[19:16], Instr[11:0]};

    // Main decoder: instruction class to datapath steering and raw enables
    always_comb begin
        branch_s     = 1'b0;
        mem_to_reg_s = 1'b0;
        mem_w_s      = 1'b0;
        alu_src_s    = 1'b0;
        imm_src_s    = 2'b00;
        reg_w_s      = 1'b0;
        reg_src_s    = 2'b00;
        alu_op_s     = 1'b0;
        case (op_s)
            2'b00: begin
                alu_src_s = funct_s[5];
                reg_w_s   = 1'b1;
                alu_op_s  = 1'b1;
            end
            2'b01: begin
                alu_src_s = 1'b1;
                imm_src_s = 2'b01;
                if (funct_s[0]) begin
                    mem_to_reg_s = 1'b1;
                    reg_w_s      = 1'b1;
                end else begin
                    mem_w_s   = 1'b1;
                    reg_src_s = 2'b10;
                end
            end
            2'b10: begin
                branch_s  = 1'b1;
                alu_src_s = 1'b1;
                imm_src_s = 2'b10;
                reg_src_s = 2'b01;
            end
            default: begin
                branch_s = 1'b0;
            end
        endcase
    end

    // ALU decoder: operation select, flag-write mask and unsupported-command kill
    always_comb begin
        alu_control_s = 2'b00;
        flag_w_s      = 2'b00;
        cmd_ok_s      = 1'b1;
        no_write_s    = 1'b0;
        if (alu_op_s) begin
            case (cmd_s)
                4'b0100: begin
                    alu_control_s = 2'b00;
                    flag_w_s      = {funct_s[0], funct_s[0]};
                end
                4'b0010: begin
                    alu_control_s = 2'b01;
                    flag_w_s      = {funct_s[0], funct_s[0]};
                end
                4'b0000: begin
                    alu_control_s = 2'b10;
                    flag_w_s      = {funct_s[0], 1'b0};
                end
                4'b1100: begin
                    alu_control_s = 2'b11;
                    flag_w_s      = {funct_s[0], 1'b0};
                end
`ifdef CONTROL_CMP_EN
                4'b1010: begin
                    alu_control_s = 2'b01;
                    flag_w_s      = 2'b11;
                    no_write_s    = 1'b1;
                end
                4'b1000: begin
                    alu_control_s = 2'b10;
                    flag_w_s      = 2'b10;
                    no_write_s    = 1'b1;
                end
`endif
                default: begin
                    cmd_ok_s = 1'b0;
                end
            endcase
        end else begin
            alu_control_s = 2'b00;
            flag_w_s      = 2'b00;
        end
    end

    assign reg_w_eff_s = reg_w_s & cmd_ok_s & ~no_write_s;
    assign mem_w_eff_s = mem_w_s & cmd_ok_s;
    assign pcs_s       = branch_s | ((rd_s == 4'd15) & reg_w_eff_s);

    // Condition evaluation against the registered flags only (no same-cycle bypass)
    always_comb begin
        case (cond_s)
            4'b0000: cond_ex_s = flags_q[2];
            4'b0001: cond_ex_s = ~flags_q[2];
            4'b0010: cond_ex_s = flags_q[1];
            4'b0011: cond_ex_s = ~flags_q[1];
            4'b0100: cond_ex_s = flags_q[3];
            4'b0101: cond_ex_s = ~flags_q[3];
            4'b0110: cond_ex_s = flags_q[0];
            4'b0111: cond_ex_s = ~flags_q[0];
            4'b1000: cond_ex_s = flags_q[1] & ~flags_q[2];
            4'b1001: cond_ex_s = ~flags_q[1] | flags_q[2];
            4'b1010: cond_ex_s = (flags_q[3] == flags_q[0]);
            4'b1011: cond_ex_s = (flags_q[3] != flags_q[0]);
            4'b1100: cond_ex_s = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'b1101: cond_ex_s = flags_q[2] | (flags_q[3] != flags_q[0]);
            4'b1110: cond_ex_s = 1'b1;
            default: cond_ex_s = 1'b0;
        endcase
    end

    // Next flag value: NZ and CV halves update independently
    always_comb begin
        flags_d = flags_q;
        if (flag_w_s[1] & cond_ex_s) begin
            flags_d[3:2] = ALUFlags[3:2];
        end else begin
            flags_d[3:2] = flags_q[3:2];
        end
        if (flag_w_s[0] & cond_ex_s) begin
            flags_d[1:0] = ALUFlags[1:0];
        end else begin
            flags_d[1:0] = flags_q[1:0];
        end
    end

    // Architectural flag register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign RegSrc     = reg_src_s;
    assign RegWrite   = reg_w_eff_s & cond_ex_s;
    assign ImmSrc     = imm_src_s;
    assign ALUSrc     = alu_src_s;
    assign ALUControl = alu_control_s;
    assign MemtoReg   = mem_to_reg_s;
    assign MemWrite   = mem_w_eff_s & cond_ex_s;
    assign PCSrc      = pcs_s & cond_ex_s;
    assign Flags      = flags_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: instruction-level reference model plus directed vectors.
module tb_control_unit;

`ifdef CONTROL_CMP_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Instr = 32'hF280_0000;
    logic [3:0]  ALUFlags = 4'b0000;
    logic [1:0]  RegSrc;
    logic        RegWrite;
    logic [1:0]  ImmSrc;
    logic        ALUSrc;
    logic [1:0]  ALUControl;
    logic        MemtoReg;
    logic        MemWrite;
    logic        PCSrc;
    logic [3:0]  Flags;

    int checks = 0;
    int failures = 0;

    control_unit dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .RegSrc(RegSrc), .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUSrc(ALUSrc),
        .ALUControl(ALUControl), .MemtoReg(MemtoReg), .MemWrite(MemWrite),
        .PCSrc(PCSrc), .Flags(Flags)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] reg_src;
        logic       reg_write;
        logic [1:0] imm_src;
        logic       imm_care;
        logic       alu_src;
        logic [1:0] alu_ctl;
        logic       alu_care;
        logic       mem_to_reg;
        logic       mem_write;
        logic       pc_src;
        logic       upd_nz;
        logic       upd_cv;
    } exp_t;

    // ARM rule: cond[3:1] picks a predicate, cond[0] inverts it; 1110 always, 1111 never
    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return c[0] ? !base : base;
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [3:0] f);
        exp_t e;
        logic pass, s, wreg, wmem, wpc, nz, cv;
        logic is_add, is_sub, is_and, is_orr, is_cmp, is_tst;
        logic [3:0] cmd, rd;
        e = '0;
        e.imm_care = 1'b1;
        e.alu_care = 1'b1;
        pass = cond_pass(ins[31:28], f);
        s = ins[20]; cmd = ins[24:21]; rd = ins[15:12];
        wreg = 1'b0; wmem = 1'b0; wpc = 1'b0; nz = 1'b0; cv = 1'b0;
        if (ins[27:26] == 2'b10) begin
            e.reg_src = 2'b01; e.imm_src = 2'b10; e.alu_src = 1'b1; wpc = 1'b1;
        end else if (ins[27:26] == 2'b01) begin
            e.alu_src = 1'b1; e.imm_src = 2'b01;
            if (s) begin
                e.mem_to_reg = 1'b1; wreg = 1'b1; wpc = (rd == 4'd15);
            end else begin
                e.reg_src = 2'b10; wmem = 1'b1;
            end
        end else if (ins[27:26] == 2'b00) begin
            e.alu_src = ins[25];
            e.imm_care = ins[25];
            is_add = (cmd == 4'd4); is_sub = (cmd == 4'd2);
            is_and = (cmd == 4'd0); is_orr = (cmd == 4'd12);
            is_cmp = CMP_EN && (cmd == 4'd10);
            is_tst = CMP_EN && (cmd == 4'd8);
            if (is_add || is_sub || is_and || is_orr) begin
                wreg = 1'b1; wpc = (rd == 4'd15);
                nz = s; cv = s && (is_add || is_sub);
                e.alu_ctl = is_add ? 2'd0 : is_sub ? 2'd1 : is_and ? 2'd2 : 2'd3;
            end else if (is_cmp) begin
                e.alu_ctl = 2'd1; nz = 1'b1; cv = 1'b1;
            end else if (is_tst) begin
                e.alu_ctl = 2'd2; nz = 1'b1;
            end else begin
                e.alu_care = 1'b0;
            end
        end
        e.reg_write = wreg && pass;
        e.mem_write = wmem && pass;
        e.pc_src    = wpc && pass;
        e.upd_nz    = nz && pass;
        e.upd_cv    = cv && pass;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    logic [3:0] m_flags = 4'b0000;
    exp_t       e_upd;
    exp_t       e_cmp;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_flags <= 4'b0000;
        end else begin
            e_upd = model(Instr, m_flags);
            if (e_upd.upd_nz) m_flags[3:2] <= ALUFlags[3:2];
            if (e_upd.upd_cv) m_flags[1:0] <= ALUFlags[1:0];
        end
    end

    always @(negedge clk) begin
        e_cmp = model(Instr, m_flags);
        chk("m_RegSrc",   32'(RegSrc),   32'(e_cmp.reg_src));
        chk("m_RegWrite", 32'(RegWrite), 32'(e_cmp.reg_write));
        if (e_cmp.imm_care) chk("m_ImmSrc", 32'(ImmSrc), 32'(e_cmp.imm_src));
        chk("m_ALUSrc",   32'(ALUSrc),   32'(e_cmp.alu_src));
        if (e_cmp.alu_care) chk("m_ALUControl", 32'(ALUControl), 32'(e_cmp.alu_ctl));
        chk("m_MemtoReg", 32'(MemtoReg), 32'(e_cmp.mem_to_reg));
        chk("m_MemWrite", 32'(MemWrite), 32'(e_cmp.mem_write));
        chk("m_PCSrc",    32'(PCSrc),    32'(e_cmp.pc_src));
        chk("m_Flags",    32'(Flags),    32'(m_flags));
    end

    task automatic apply(input logic [31:0] i, input logic [3:0] a);
        @(posedge clk);
        #1;
        Instr = i;
        ALUFlags = a;
        #2;
    endtask

    localparam logic [3:0] SWEEP [7] = '{4'b0000, 4'b1000, 4'b0100, 4'b0010,
                                         4'b0001, 4'b1001, 4'b0110};

    initial begin
        @(posedge clk);
        #1;
        chk("reset_flags", 32'(Flags), 32'h0);
        chk("reset_nop_regwrite", 32'(RegWrite), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        apply(32'hE280_002A, 4'b1111);
        chk("add_RegSrc", 32'(RegSrc), 32'h0);
        chk("add_RegWrite", 32'(RegWrite), 32'h1);
        chk("add_ImmSrc", 32'(ImmSrc), 32'h0);
        chk("add_ALUSrc", 32'(ALUSrc), 32'h1);
        chk("add_ALUControl", 32'(ALUControl), 32'h0);
        chk("add_MemtoReg", 32'(MemtoReg), 32'h0);
        chk("add_MemWrite", 32'(MemWrite), 32'h0);
        chk("add_PCSrc", 32'(PCSrc), 32'h0);

        apply(32'hE250_0001, 4'b0100);
        chk("add_flags_held", 32'(Flags), 32'h0);
        chk("subs_ALUControl", 32'(ALUControl), 32'h1);
        apply(32'h0A00_0002, 4'b0000);
        chk("subs_flags", 32'(Flags), 32'h4);
        chk("beq_PCSrc", 32'(PCSrc), 32'h1);
        chk("beq_RegWrite", 32'(RegWrite), 32'h0);
        chk("beq_ImmSrc", 32'(ImmSrc), 32'h2);
        chk("beq_RegSrc", 32'(RegSrc), 32'h1);

        apply(32'hE290_0000, 4'b0000);
        apply(32'h0A00_0002, 4'b0000);
        chk("adds_clear_flags", 32'(Flags), 32'h0);
        chk("beq_not_taken", 32'(PCSrc), 32'h0);
        apply(32'h1A00_0002, 4'b0000);
        chk("bne_taken", 32'(PCSrc), 32'h1);
        apply(32'h0280_0001, 4'b1111);
        chk("addeq_RegWrite", 32'(RegWrite), 32'h0);
        apply(32'h0290_0001, 4'b1111);
        chk("addseq_RegWrite", 32'(RegWrite), 32'h0);
        apply(32'hE591_0004, 4'b0000);
        chk("addseq_flags_held", 32'(Flags), 32'h0);
        chk("ldr_MemtoReg", 32'(MemtoReg), 32'h1);
        chk("ldr_RegWrite", 32'(RegWrite), 32'h1);
        chk("ldr_ImmSrc", 32'(ImmSrc), 32'h1);
        chk("ldr_ALUSrc", 32'(ALUSrc), 32'h1);
        apply(32'hE581_0004, 4'b0000);
        chk("str_MemWrite", 32'(MemWrite), 32'h1);
        chk("str_RegWrite", 32'(RegWrite), 32'h0);
        chk("str_RegSrc", 32'(RegSrc), 32'h2);
        apply(32'hE28F_F004, 4'b0000);
        chk("addpc_PCSrc", 32'(PCSrc), 32'h1);
        chk("addpc_RegWrite", 32'(RegWrite), 32'h1);

        apply(32'hE350_0000, 4'b0110);
        chk("cmp_RegWrite", 32'(RegWrite), 32'h0);
        apply(32'hF280_0000, 4'b0000);
        chk("cmp_flags", 32'(Flags), CMP_EN ? 32'h6 : 32'h0);

        apply(32'hE290_0000, 4'b1000);
        apply(32'hBA00_0002, 4'b0000);
        chk("blt_taken", 32'(PCSrc), 32'h1);
        apply(32'hAA00_0002, 4'b0000);
        chk("bge_not_taken", 32'(PCSrc), 32'h0);

        for (int k = 0; k < 7; k++) begin
            apply(32'hE290_0000, SWEEP[k]);
            for (int c = 0; c < 16; c++) begin
                apply({c[3:0], 28'hA00_0002}, 4'b1111);
            end
        end

        apply(32'hE290_0000, 4'b1001);
        apply(32'hF280_0000, 4'b0000);
        chk("pre_reset_flags", 32'(Flags), 32'h9);
        chk("never_RegWrite", 32'(RegWrite), 32'h0);
        chk("never_MemWrite", 32'(MemWrite), 32'h0);
        chk("never_PCSrc", 32'(PCSrc), 32'h0);
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset_flags", 32'(Flags), 32'h0);
        apply(32'hE290_0000, 4'b1111);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("reset_edge_no_update", 32'(Flags), 32'h0);
        apply(32'hF280_0000, 4'b0000);
        chk("post_reset_update", 32'(Flags), 32'hF);
        @(negedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
